// File: rtl/acq_pkg.sv
// acq_pkg: shared types and default parameter values for the acquisition sequencer.
package acq_pkg;

  localparam int CFG_BITS_DEF      = 32;
  localparam int FRAME_SAMPLES_DEF = 256;
  localparam int GUARD_CYC_DEF     = 200;
  localparam int WDT_CYC_DEF       = 4096;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_GRD_L2R = 3'd2,
    ST_READ    = 3'd3,
    ST_GRD_R2L = 3'd4
  } acq_state_e;

  // Bits needed to hold the values 0 .. n-1 (never less than one bit).
  function automatic int cnt_width(input int n);
    if (n <= 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/acq_sequencer_if.sv
// acq_sequencer_if: host-side control and status bundle of the acquisition sequencer.
interface acq_sequencer_if;

  logic        start;
  logic        stop;
  logic        cfg_req;
  logic        load_clk;
  logic        adc_clk;
  logic        r_l_con;
  logic        cfg_ack;
  logic        frame_done;
  logic [15:0] sample_cnt;
  logic        busy;
  logic [2:0]  state;
  logic        err;

  modport master (
    output start, stop, cfg_req, load_clk, adc_clk,
    input  r_l_con, cfg_ack, frame_done, sample_cnt, busy, state, err
  );

  modport slave (
    input  start, stop, cfg_req, load_clk, adc_clk,
    output r_l_con, cfg_ack, frame_done, sample_cnt, busy, state, err
  );

endinterface

// File: rtl/acq_sequencer_rise_det.sv
// rise_det: registered rising-edge detector; the pulse appears one cycle after
// the first high sample that follows a low sample.
module rise_det (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_i,
  output logic rise_o
);

  logic prev_q;
  logic rise_q;

  // Remember the previous sample and register the high-after-low condition.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      prev_q <= sig_i;
      rise_q <= sig_i & ~prev_q;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/acq_sequencer.sv
// acq_sequencer: sequences configuration LOAD and data READ phases of a
// detector clock generator, with guard dead-time between phase changes.
// Optional watchdog on missing load/adc edges: define ACQ_SEQ_WDT_EN.
module acq_sequencer
  import acq_pkg::*;
#(
  parameter int CFG_BITS      = CFG_BITS_DEF,
  parameter int FRAME_SAMPLES = FRAME_SAMPLES_DEF,
  parameter int GUARD_CYC     = GUARD_CYC_DEF,
  parameter int WDT_CYC       = WDT_CYC_DEF
) (
  input  logic           sys_clk,
  input  logic           rst_n,
  acq_sequencer_if.slave bus
);

  localparam int BW = cnt_width(CFG_BITS);
  localparam int GW = cnt_width(GUARD_CYC);
  localparam logic [BW-1:0] BIT_LAST = BW'(CFG_BITS - 1);
  localparam logic [GW-1:0] GRD_LAST = GW'(GUARD_CYC - 1);
  localparam logic [15:0]   SMP_LAST = 16'(FRAME_SAMPLES - 1);

  if ((CFG_BITS < 1) || (FRAME_SAMPLES < 1) || (FRAME_SAMPLES > 65536) ||
      (GUARD_CYC < 1) || (WDT_CYC < 2)) begin : g_bad_params
    $error("acq_sequencer: parameter out of range");
  end

  acq_state_e    state_q, state_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [GW-1:0] grd_cnt_q, grd_cnt_d;
  logic [15:0]   smp_cnt_q, smp_cnt_d;
  logic          stop_q, stop_d;
  logic          r_l_con_q, r_l_con_d;
  logic          cfg_ack_q, cfg_ack_d;
  logic          frame_done_q, frame_done_d;
  logic          busy_q, busy_d;
  logic          load_rise_s, adc_rise_s;
  logic          load_end_s, frame_end_s, grd_end_s;
  logic          stop_pend_s;
  logic          wdt_exp_s;

  rise_det u_load_det (.clk(sys_clk), .rst_n(rst_n), .sig_i(bus.load_clk), .rise_o(load_rise_s));
  rise_det u_adc_det  (.clk(sys_clk), .rst_n(rst_n), .sig_i(bus.adc_clk),  .rise_o(adc_rise_s));

  assign load_end_s  = load_rise_s && (bit_cnt_q == BIT_LAST);
  assign frame_end_s = adc_rise_s && (smp_cnt_q == SMP_LAST);
  assign grd_end_s   = (grd_cnt_q == GRD_LAST);
  // A stop arriving this cycle counts as latched so boundaries never miss it.
  assign stop_pend_s = stop_q | (bus.stop & ((state_q == ST_LOAD) ||
                                             (state_q == ST_GRD_L2R) ||
                                             (state_q == ST_READ)));

  // State register.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decision; stop beats a pending reload at every boundary.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) state_d = ST_LOAD;
        else           state_d = ST_IDLE;
      end
      ST_LOAD: begin
        if (wdt_exp_s)       state_d = ST_IDLE;
        else if (load_end_s) state_d = ST_GRD_L2R;
        else                 state_d = ST_LOAD;
      end
      ST_GRD_L2R: begin
        if (grd_end_s && stop_pend_s) state_d = ST_IDLE;
        else if (grd_end_s)           state_d = ST_READ;
        else                          state_d = ST_GRD_L2R;
      end
      ST_READ: begin
        if (wdt_exp_s)                        state_d = ST_IDLE;
        else if (frame_end_s && stop_pend_s)  state_d = ST_IDLE;
        else if (frame_end_s && bus.cfg_req)  state_d = ST_GRD_R2L;
        else                                  state_d = ST_READ;
      end
      ST_GRD_R2L: begin
        if (grd_end_s) state_d = ST_LOAD;
        else           state_d = ST_GRD_R2L;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output next values, taken from the next state so outputs are registered.
  always_comb begin
    r_l_con_d    = (state_d == ST_LOAD);
    busy_d       = (state_d != ST_IDLE);
    cfg_ack_d    = (state_q == ST_GRD_R2L) && (state_d == ST_LOAD);
    frame_done_d = (state_q == ST_READ) && frame_end_s;
  end

  // Counter and stop-latch next values; each counter is zero outside its state.
  always_comb begin
    if (state_q != ST_LOAD)  bit_cnt_d = '0;
    else if (load_end_s)     bit_cnt_d = '0;
    else if (load_rise_s)    bit_cnt_d = bit_cnt_q + 1'b1;
    else                     bit_cnt_d = bit_cnt_q;

    if (((state_q == ST_GRD_L2R) || (state_q == ST_GRD_R2L)) && (state_d == state_q))
      grd_cnt_d = grd_cnt_q + 1'b1;
    else
      grd_cnt_d = '0;

    if (state_q != ST_READ)  smp_cnt_d = '0;
    else if (frame_end_s)    smp_cnt_d = '0;
    else if (adc_rise_s)     smp_cnt_d = smp_cnt_q + 16'd1;
    else                     smp_cnt_d = smp_cnt_q;

    if (state_d == ST_IDLE)  stop_d = 1'b0;
    else                     stop_d = stop_pend_s;
  end

  // Datapath and output registers.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      bit_cnt_q    <= '0;
      grd_cnt_q    <= '0;
      smp_cnt_q    <= 16'd0;
      stop_q       <= 1'b0;
      r_l_con_q    <= 1'b0;
      cfg_ack_q    <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      bit_cnt_q    <= bit_cnt_d;
      grd_cnt_q    <= grd_cnt_d;
      smp_cnt_q    <= smp_cnt_d;
      stop_q       <= stop_d;
      r_l_con_q    <= r_l_con_d;
      cfg_ack_q    <= cfg_ack_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
    end
  end

`ifdef ACQ_SEQ_WDT_EN
  localparam int WW = cnt_width(WDT_CYC);
  localparam logic [WW-1:0] WDT_LAST = WW'(WDT_CYC - 1);

  logic [WW-1:0] wdt_cnt_q, wdt_cnt_d;
  logic          err_q, err_d;
  logic          wdt_armed_s, exp_edge_s;

  // Watchdog: count cycles since the last expected edge in LOAD or READ.
  always_comb begin
    if (state_q == ST_LOAD) begin
      wdt_armed_s = 1'b1;
      exp_edge_s  = load_rise_s;
    end else if (state_q == ST_READ) begin
      wdt_armed_s = 1'b1;
      exp_edge_s  = adc_rise_s;
    end else begin
      wdt_armed_s = 1'b0;
      exp_edge_s  = 1'b0;
    end
    wdt_exp_s = wdt_armed_s && !exp_edge_s && (wdt_cnt_q == WDT_LAST);
    if (!wdt_armed_s || exp_edge_s) wdt_cnt_d = '0;
    else                            wdt_cnt_d = wdt_cnt_q + 1'b1;
    err_d = err_q | wdt_exp_s;
  end

  // Watchdog registers; err is sticky until reset.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      wdt_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      wdt_cnt_q <= wdt_cnt_d;
      err_q     <= err_d;
    end
  end

  assign bus.err = err_q;
`else
  assign wdt_exp_s = 1'b0;
  assign bus.err   = 1'b0;
`endif

  assign bus.r_l_con    = r_l_con_q;
  assign bus.cfg_ack    = cfg_ack_q;
  assign bus.frame_done = frame_done_q;
  assign bus.sample_cnt = smp_cnt_q;
  assign bus.busy       = busy_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_acq_sequencer.sv
// tb_acq_sequencer: directed self-checking bench for acq_sequencer (default parameters).
module tb_acq_sequencer;
  import acq_pkg::*;

  logic sys_clk = 1'b0;
  logic rst_n;
  int   vectors     = 0;
  int   miscompares = 0;
  int   fd_seen     = 0;
  int   ack_seen    = 0;
  int   n;

  acq_sequencer_if bus ();

  acq_sequencer dut (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  // Pulse counters sampled on the inactive edge.
  always @(negedge sys_clk) begin
    if (bus.frame_done === 1'b1) fd_seen++;
    if (bus.cfg_ack === 1'b1) ack_seen++;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge sys_clk);
  endtask

  task automatic load_pulse();
    bus.load_clk = 1'b1; step();
    bus.load_clk = 1'b0; step();
  endtask

  task automatic adc_pulses(input int cnt);
    for (int i = 0; i < cnt; i++) begin
      bus.adc_clk = 1'b1; step();
      bus.adc_clk = 1'b0; step();
    end
  endtask

  task automatic load_pulses(input int cnt, output int rl_low);
    rl_low = 0;
    for (int i = 0; i < cnt; i++) begin
      load_pulse();
      if (bus.r_l_con !== 1'b1) rl_low++;
    end
  endtask

  task automatic pulse_start();
    bus.start = 1'b1; step(); bus.start = 1'b0;
  endtask

  task automatic pulse_stop();
    bus.stop = 1'b1; step(); bus.stop = 1'b0;
  endtask

  // Number of consecutive negedges spent in state st, bounded by limit.
  task automatic count_state(input logic [2:0] st, input int limit, output int cnt);
    cnt = 0;
    while ((bus.state === st) && (cnt < limit)) begin
      cnt++;
      step();
    end
  endtask

  initial begin
    int rl_low;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.stop = 1'b0; bus.cfg_req = 1'b0;
    bus.load_clk = 1'b0; bus.adc_clk = 1'b0;
    repeat (3) step();
    check("rst_state", 32'(bus.state), 32'(ST_IDLE));
    check("rst_r_l_con", 32'(bus.r_l_con), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_cfg_ack", 32'(bus.cfg_ack), 32'd0);
    check("rst_frame_done", 32'(bus.frame_done), 32'd0);
    check("rst_sample_cnt", 32'(bus.sample_cnt), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    rst_n = 1'b1;
    step();

    // stop in IDLE has no effect on the following run
    pulse_stop();
    check("idle_stop_state", 32'(bus.state), 32'(ST_IDLE));
    pulse_start();
    check("start_state", 32'(bus.state), 32'(ST_LOAD));
    check("start_r_l_con", 32'(bus.r_l_con), 32'd1);
    check("start_busy", 32'(bus.busy), 32'd1);

    // first configuration load: 32 bits
    load_pulses(31, rl_low);
    check("load31_state", 32'(bus.state), 32'(ST_LOAD));
    check("load_r_l_con_low", 32'(rl_low), 32'd0);
    load_pulse();
    check("load32_state", 32'(bus.state), 32'(ST_GRD_L2R));
    check("grd_l2r_r_l_con", 32'(bus.r_l_con), 32'd0);
    count_state(ST_GRD_L2R, 1000, n);
    check("grd_l2r_len", 32'(n), 32'd200);
    check("read_state", 32'(bus.state), 32'(ST_READ));
    check("read_r_l_con", 32'(bus.r_l_con), 32'd0);
    check("read_busy", 32'(bus.busy), 32'd1);
    check("read_sample0", 32'(bus.sample_cnt), 32'd0);

    // frame 1, start ignored in READ
    adc_pulses(10);
    pulse_start();
    check("read_start_ignored", 32'(bus.state), 32'(ST_READ));
    check("sample10", 32'(bus.sample_cnt), 32'd10);
    adc_pulses(245);
    check("sample255", 32'(bus.sample_cnt), 32'd255);
    check("fd_before_end", 32'(bus.frame_done), 32'd0);
    adc_pulses(1);
    check("frame1_wrap", 32'(bus.sample_cnt), 32'd0);
    check("frame1_done", 32'(bus.frame_done), 32'd1);
    check("frame1_stay_read", 32'(bus.state), 32'(ST_READ));
    step();
    check("frame1_done_pulse", 32'(bus.frame_done), 32'd0);
    #1;
    check("frame1_done_count", 32'(fd_seen), 32'd1);

    // frame 2 with cfg_req raised at sample 100
    adc_pulses(100);
    check("sample100", 32'(bus.sample_cnt), 32'd100);
    bus.cfg_req = 1'b1;
    adc_pulses(156);
    check("frame2_done", 32'(bus.frame_done), 32'd1);
    check("grd_r2l_state", 32'(bus.state), 32'(ST_GRD_R2L));
    check("grd_r2l_r_l_con", 32'(bus.r_l_con), 32'd0);
    count_state(ST_GRD_R2L, 1000, n);
    check("grd_r2l_len", 32'(n), 32'd200);
    check("reload_state", 32'(bus.state), 32'(ST_LOAD));
    check("reload_cfg_ack", 32'(bus.cfg_ack), 32'd1);
    check("reload_r_l_con", 32'(bus.r_l_con), 32'd1);
    bus.cfg_req = 1'b0;
    step();
    check("cfg_ack_pulse", 32'(bus.cfg_ack), 32'd0);
    #1;
    check("ack_count1", 32'(ack_seen), 32'd1);

    // reload, then stop and cfg_req both pending at the boundary
    load_pulses(31, rl_low);
    check("reload31_state", 32'(bus.state), 32'(ST_LOAD));
    load_pulse();
    count_state(ST_GRD_L2R, 1000, n);
    check("grd_l2r_len2", 32'(n), 32'd200);
    check("read_state2", 32'(bus.state), 32'(ST_READ));
    adc_pulses(50);
    pulse_stop();
    adc_pulses(10);
    bus.cfg_req = 1'b1;
    adc_pulses(196);
    check("stopwin_state", 32'(bus.state), 32'(ST_IDLE));
    check("stopwin_frame_done", 32'(bus.frame_done), 32'd1);
    check("stopwin_busy", 32'(bus.busy), 32'd0);
    check("stopwin_sample", 32'(bus.sample_cnt), 32'd0);
    repeat (250) step();
    check("stopwin_still_idle", 32'(bus.state), 32'(ST_IDLE));
    #1;
    check("stopwin_no_ack", 32'(ack_seen), 32'd1);
    bus.cfg_req = 1'b0;

    // reset in the middle of a load, at bit 17
    step();
    pulse_start();
    load_pulses(17, rl_low);
    check("mid_load_state", 32'(bus.state), 32'(ST_LOAD));
    rst_n = 1'b0;
    step();
    check("midrst_state", 32'(bus.state), 32'(ST_IDLE));
    check("midrst_r_l_con", 32'(bus.r_l_con), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_cfg_ack", 32'(bus.cfg_ack), 32'd0);
    check("midrst_frame_done", 32'(bus.frame_done), 32'd0);
    check("midrst_err", 32'(bus.err), 32'd0);
    rst_n = 1'b1;
    step();
    #1;
    check("midrst_fd_count", 32'(fd_seen), 32'd3);
    check("midrst_ack_count", 32'(ack_seen), 32'd1);

    // full 32-bit reload with a stop latched during LOAD
    pulse_start();
    load_pulses(10, rl_low);
    pulse_stop();
    load_pulses(21, rl_low);
    check("stopload31_state", 32'(bus.state), 32'(ST_LOAD));
    load_pulse();
    check("stopload32_state", 32'(bus.state), 32'(ST_GRD_L2R));
    count_state(ST_GRD_L2R, 1000, n);
    check("stopload_grd_len", 32'(n), 32'd200);
    check("stopload_idle", 32'(bus.state), 32'(ST_IDLE));
    check("stopload_busy", 32'(bus.busy), 32'd0);

`ifdef ACQ_SEQ_WDT_EN
    // adc_clk stuck in READ trips the watchdog
    pulse_start();
    load_pulses(32, rl_low);
    count_state(ST_GRD_L2R, 1000, n);
    check("wdt_read_entry", 32'(bus.state), 32'(ST_READ));
    count_state(ST_READ, 10000, n);
    check("wdt_read_len", 32'(n), 32'd4096);
    check("wdt_state", 32'(bus.state), 32'(ST_IDLE));
    check("wdt_err", 32'(bus.err), 32'd1);
    check("wdt_r_l_con", 32'(bus.r_l_con), 32'd0);
`else
    check("err_tied_low", 32'(bus.err), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
